// File: rtl/hex_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : hex_rom_loader
// Description : Program-memory load controller. Turns an HPS download stream
//               (raw BIN image or Intel HEX text) into ROM byte writes, checks
//               HEX record checksums and holds the CPU in reset while the ROM
//               is being rewritten.
// Ports       : clk, rst_n              - clock, async active-low reset
//               dl_active/dl_wr        - download window / byte strobe
//               dl_index               - 0 = BIN, nonzero = Intel HEX
//               dl_addr/dl_data        - BIN byte address / download byte
//               mem_we/mem_addr/mem_wdata - ROM byte write port
//               cpu_hold               - CPU reset request (16-cycle tail)
//               busy                   - parser not idle
//               err_csum/err_fmt       - sticky error flags
//               rec_count              - good data records (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module hex_rom_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [7:0]  dl_index,
    input  logic [14:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        err_csum,
    output logic        err_fmt,
    output logic [7:0]  rec_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_BIN, S_SYNC, S_LEN_H, S_LEN_L, S_A3, S_A2, S_A1,
        S_A0, S_TYP_H, S_TYP_L, S_DAT_H, S_DAT_L, S_CS_H, S_CS_L, S_DONE
    } state_t;

    localparam logic [4:0] c_TAIL_LOAD = 5'd16;

    state_t      r_state;
    logic        r_act_q;     // dl_active delayed, for edge detection
    logic        r_dl_on;     // a download whose start edge was seen
    logic [4:0]  r_tail;
    logic        r_cpu_hold;
    logic        r_mem_we;
    logic [14:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_err_csum;
    logic        r_err_fmt;
    logic [7:0]  r_rec_count;
    logic [3:0]  r_nib;       // high nibble of the byte being assembled
    logic [7:0]  r_len;
    logic [15:0] r_addr;
    logic [7:0]  r_typ;
    logic [7:0]  r_sum;
    logic [7:0]  r_cnt;

    logic        w_rise;
    logic        w_fall;
    logic        w_wr;
    logic        w_is_hex;
    logic [3:0]  w_nib;
    logic [7:0]  w_byte;
    logic [7:0]  w_sum;
    logic [15:0] w_wr_addr;
    logic [7:0]  w_cnt_nx;

    assign w_rise    = dl_active & ~r_act_q;
    assign w_fall    = ~dl_active & r_dl_on;
    assign w_wr      = dl_wr & dl_active;
    assign w_byte    = {r_nib, w_nib};
    assign w_sum     = r_sum + w_byte;
    assign w_wr_addr = r_addr + {8'h00, r_cnt};
    assign w_cnt_nx  = r_cnt + 8'd1;

    // ASCII hex digit decode; letters map via low nibble + 9 ('A'/'a' -> 0xA)
    always_comb begin
        w_is_hex = 1'b1;
        w_nib    = 4'h0;
        if (dl_data >= 8'h30 && dl_data <= 8'h39) begin
            w_nib = dl_data[3:0];
        end else if ((dl_data >= 8'h41 && dl_data <= 8'h46) ||
                     (dl_data >= 8'h61 && dl_data <= 8'h66)) begin
            w_nib = dl_data[3:0] + 4'd9;
        end else begin
            w_is_hex = 1'b0;
        end
    end

    // Download tracking and CPU hold. r_act_q resets high so a download
    // already running when reset releases is not mistaken for a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_q    <= 1'b1;
            r_dl_on    <= 1'b0;
            r_tail     <= 5'd0;
            r_cpu_hold <= 1'b0;
        end else begin
            r_act_q <= dl_active;
            if (w_rise) begin
                r_dl_on    <= 1'b1;
                r_cpu_hold <= 1'b1;
            end else if (w_fall) begin
                r_dl_on <= 1'b0;
                r_tail  <= c_TAIL_LOAD;
            end else if (r_cpu_hold && !r_dl_on) begin
                if (r_tail == 5'd0) begin
                    r_cpu_hold <= 1'b0;
                end else begin
                    r_tail <= r_tail - 5'd1;
                end
            end
        end
    end

    // Parser FSM with registered write port and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 15'd0;
            r_mem_wdata <= 8'd0;
            r_err_csum  <= 1'b0;
            r_err_fmt   <= 1'b0;
            r_rec_count <= 8'd0;
            r_nib       <= 4'd0;
            r_len       <= 8'd0;
            r_addr      <= 16'd0;
            r_typ       <= 8'd0;
            r_sum       <= 8'd0;
            r_cnt       <= 8'd0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_rise) begin
                r_err_csum  <= 1'b0;
                r_err_fmt   <= 1'b0;
                r_rec_count <= 8'd0;
                r_state     <= (dl_index == 8'd0) ? S_BIN : S_SYNC;
            end else if (w_fall) begin
                r_state <= S_IDLE;
                // A HEX download must have reached its EOF record
                if (r_state != S_BIN && r_state != S_DONE) begin
                    r_err_fmt <= 1'b1;
                end
            end else if (w_wr) begin
                if (r_state == S_BIN) begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= dl_addr;
                    r_mem_wdata <= dl_data;
                end else if (r_state == S_SYNC) begin
                    if (dl_data == 8'h3A) begin
                        r_state <= S_LEN_H;
                        r_sum   <= 8'd0;
                        r_cnt   <= 8'd0;
                    end
                end else if (r_state == S_IDLE || r_state == S_DONE) begin
                    r_state <= r_state;
                end else if (!w_is_hex) begin
                    r_err_fmt <= 1'b1;
                    r_state   <= S_SYNC;
                end else begin
                    case (r_state)
                        S_LEN_H, S_A3, S_A1, S_TYP_H, S_DAT_H, S_CS_H: begin
                            r_nib   <= w_nib;
                            r_state <= state_t'(r_state + 4'd1);
                        end
                        S_LEN_L: begin
                            r_len   <= w_byte;
                            r_sum   <= w_sum;
                            r_state <= S_A3;
                        end
                        S_A2: begin
                            r_addr[15:8] <= w_byte;
                            r_sum        <= w_sum;
                            r_state      <= S_A1;
                        end
                        S_A0: begin
                            r_addr[7:0] <= w_byte;
                            r_sum       <= w_sum;
                            r_state     <= S_TYP_H;
                        end
                        S_TYP_L: begin
                            r_typ   <= w_byte;
                            r_sum   <= w_sum;
                            r_state <= (r_len != 8'd0) ? S_DAT_H : S_CS_H;
                        end
                        S_DAT_L: begin
                            r_sum <= w_sum;
                            r_cnt <= w_cnt_nx;
                            if (r_typ == 8'h00) begin
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= w_wr_addr[14:0];
                                r_mem_wdata <= w_byte;
                            end
                            r_state <= (w_cnt_nx == r_len) ? S_CS_H : S_DAT_H;
                        end
                        S_CS_L: begin
                            if (w_sum != 8'd0) begin
                                r_err_csum <= 1'b1;
                            end else if (r_typ == 8'h00 && r_rec_count != 8'hFF) begin
                                r_rec_count <= r_rec_count + 8'd1;
                            end
                            r_state <= (r_typ == 8'h01 && w_sum == 8'd0) ? S_DONE : S_SYNC;
                        end
                        default: r_state <= S_SYNC;
                    endcase
                end
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_hold  = r_cpu_hold;
    assign busy      = (r_state != S_IDLE);
    assign err_csum  = r_err_csum;
    assign err_fmt   = r_err_fmt;
    assign rec_count = r_rec_count;

endmodule
`default_nettype wire

// File: tb/tb_hex_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_rom_loader
// Description : Self-checking bench for hex_rom_loader. Stimulus pushes the
//               expected ROM writes into a queue; a monitor pops and compares
//               every mem_we pulse. Status outputs are checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_rom_loader;

    logic        clk;
    logic        rst_n;
    logic        dl_active;
    logic        dl_wr;
    logic [7:0]  dl_index;
    logic [14:0] dl_addr;
    logic [7:0]  dl_data;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        err_csum;
    logic        err_fmt;
    logic [7:0]  rec_count;

    int checks = 0;
    int errors = 0;
    logic [22:0] exp_q[$];   // {addr, data}

    hex_rom_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_index  (dl_index),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .err_csum  (err_csum),
        .err_fmt   (err_fmt),
        .rec_count (rec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every write pulse must match the head of the queue
    always @(negedge clk) begin
        if (mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                         mem_addr, mem_wdata);
            end else begin
                logic [22:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wdata, e[22:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chk_drained(input string name);
        repeat (2) @(posedge clk);
        #1;
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic push(input logic [14:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    // All drive tasks start and end 1 time unit after a rising edge
    task automatic send(input logic [7:0] c);
        dl_wr   = 1'b1;
        dl_data = c;
        @(posedge clk);
        #1;
        dl_wr = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        dl_index  = idx;
        dl_active = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic end_dl();
        dl_active = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0;
        dl_index = 8'd0; dl_addr = 15'd0; dl_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_outs", {mem_we, cpu_hold, busy, err_csum, err_fmt, rec_count}, 0);

        // ---- BIN load and cpu_hold tail ----
        start_dl(8'd0);
        chk("bin_hold_rise", cpu_hold, 1);
        push(15'd0, 8'h0C); dl_addr = 15'd0; send(8'h0C);
        push(15'd1, 8'h94); dl_addr = 15'd1; send(8'h94);
        end_dl();
        chk("bin_busy_end", busy, 0);
        repeat (16) @(posedge clk);
        #1;
        chk("hold_tail_16", cpu_hold, 1);
        @(posedge clk);
        #1;
        chk("hold_tail_17", cpu_hold, 0);
        chk_drained("bin_drained");

        // ---- good HEX data record (checksum 0x100-0x1E = E2) then EOF ----
        start_dl(8'd1);
        push(15'h0010, 8'h01); push(15'h0011, 8'h02);
        push(15'h0012, 8'h03); push(15'h0013, 8'h04);
        send_str(":0400100001020304e2\r\n");
        send_str(":00000001FF\r\n");
        send_str(":0100300077A8");        // after EOF: must be ignored
        chk("hex_busy_done", busy, 1);
        end_dl();
        chk("hex_rec", rec_count, 1);
        chk("hex_errs", {err_csum, err_fmt}, 0);
        chk_drained("hex_drained");

        // ---- bad checksum: byte still written ----
        start_dl(8'd2);
        chk("clear_on_start", rec_count, 0);
        push(15'h0000, 8'h55);
        send_str(":0100000055AB");
        chk("csum_err", err_csum, 1);
        chk("csum_rec", rec_count, 0);
        send_str(":00000001FF");
        end_dl();
        chk("csum_fmt", err_fmt, 0);
        chk_drained("csum_drained");

        // ---- illegal character, recovery, non-data record type ----
        start_dl(8'd1);
        chk("csum_cleared", err_csum, 0);
        send_str(":02000G");
        chk("illegal_fmt", err_fmt, 1);
        push(15'h0020, 8'hAA);
        send_str(":01002000AA35\n");
        send_str(":020000040000FA\n");
        send_str(":00000001FF");
        end_dl();
        chk("illegal_rec", rec_count, 1);
        chk("illegal_csum", err_csum, 0);
        chk("illegal_sticky", err_fmt, 1);
        chk_drained("illegal_drained");

        // ---- address wrap, 15-bit truncation, missing EOF ----
        start_dl(8'd1);
        chk("fmt_cleared", err_fmt, 0);
        push(15'h7FFF, 8'h11); push(15'h0000, 8'h22);
        send_str(":027FFF0011224D");
        push(15'h0005, 8'h77);
        send_str(":018005007703");
        chk("wrap_fmt_before_end", err_fmt, 0);
        end_dl();
        chk("wrap_rec", rec_count, 2);
        chk("wrap_noeof_fmt", err_fmt, 1);
        chk("wrap_csum", err_csum, 0);
        chk_drained("wrap_drained");

        // ---- reset in the middle of a data record ----
        repeat (20) @(posedge clk);
        #1;
        start_dl(8'd1);
        push(15'h0000, 8'h11);
        send_str(":0200000011");
        send(8'h32);                     // DAT_H of second byte
        dl_wr = 1'b1; dl_data = 8'h32;   // DAT_L arrives with reset
        rst_n = 1'b0;
        #2;
        chk("rst_outs", {mem_we, cpu_hold, busy, err_csum, err_fmt, rec_count}, 0);
        @(posedge clk);
        #1;
        dl_wr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_str("2A9:0100000033CC");    // untracked download: ignored
        chk("rst_untracked_busy", busy, 0);
        end_dl();
        repeat (20) @(posedge clk);
        #1;
        chk("rst_after_outs", {cpu_hold, busy, err_csum, err_fmt, rec_count}, 0);
        chk_drained("rst_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
